div_seq: RTL and testbench

Iterative sequencer for the RV32M divide/remainder operations (DIV, DIVU, REM, REMU). It replaces single-cycle `/` and `%` in the execute stage with a one-bit-per-cycle restoring divider. It uses a valid/ready request and response handshake, so the pipeline control stalls execute while the divider is busy. It sits beside the ALU and shares its operand sources.

---
 rtl/rv32i_pkg.sv | 21 ++
 rtl/div_seq.sv | 157 +++++++++++++++
 tb/tb_div_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32 definitions: data width and divider encodings.
// Holds the operation and state enums used by div_seq.
package rv32i_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit
// per cycle, with valid/ready request and response handshakes.
// Ports: clk, rst (sync, high), req_valid/req_ready, op, dividend,
// divisor, resp_valid/resp_ready, result, busy (stall request).
module div_seq
    import rv32i_pkg::*;
#(
    parameter int XLEN = rv32i_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  div_op_e         op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;
    logic            is_rem_q, is_rem_d;
    logic            last_q, last_d;

    logic            sgn_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            ovf;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        is_rem_d = is_rem_q;
        last_d   = last_q;

        sgn_op = ~op[0];
        a_neg  = sgn_op & dividend[XLEN-1];
        b_neg  = sgn_op & divisor[XLEN-1];
        abs_a  = a_neg ? -dividend : dividend;
        abs_b  = b_neg ? -divisor : divisor;
        ovf    = sgn_op && (dividend == MIN_NEG) && (divisor == '1);

        // Remainder stays below the divisor, so XLEN bits hold it;
        // the shifted value needs one extra bit for the trial subtract.
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        quo_fix = neg_q_q ? -quo_q : quo_q;
        rem_fix = neg_r_q ? -rem_q : rem_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (req_valid) begin
                    is_rem_d = op[1];
                    if (divisor == '0) begin
                        result_d = op[1] ? dividend : '1;
                        state_d  = DIV_DONE;
                    end else if (ovf) begin
                        result_d = op[1] ? '0 : dividend;
                        state_d  = DIV_DONE;
                    end else begin
                        quo_d   = abs_a;
                        rem_d   = '0;
                        dvs_d   = abs_b;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        cnt_d   = CNT_W'(XLEN - 1);
                        last_d  = 1'b0;
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                if (last_q) begin
                    // Extra cycle after the final bit applies the signs.
                    result_d = is_rem_q ? rem_fix : quo_fix;
                    last_d   = 1'b0;
                    state_d  = DIV_DONE;
                end else begin
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == '0) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            DIV_DONE: begin
                if (resp_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_rem_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            is_rem_q <= is_rem_d;
            last_q   <= last_d;
        end
    end

    assign req_ready  = (state_q == DIV_IDLE);
    assign resp_valid = (state_q == DIV_DONE);
    assign busy       = (state_q != DIV_IDLE);
    assign result     = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: reference model, latency,
// backpressure and mid-operation reset checks.
module tb_div_seq;
    import rv32i_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    div_op_e     op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        busy;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    div_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input div_op_e o, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic signed [31:0] sa;
        logic signed [31:0] sb_;
        logic        sgn;
        logic        rem;
        sa  = a;
        sb_ = b;
        sgn = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
        rem = (o == DIV_OP_REM) || (o == DIV_OP_REMU);
        e.lat = 33;
        if (b == 32'h0) begin
            e.res = rem ? a : 32'hFFFF_FFFF;
            e.lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = rem ? 32'h0 : a;
            e.lat = 1;
        end else if (sgn) begin
            e.res = rem ? sa % sb_ : sa / sb_;
        end else begin
            e.res = rem ? a % b : a / b;
        end
        return e;
    endfunction

    task automatic issue(input div_op_e o, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        op        = o;
        dividend  = a;
        divisor   = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        if (push) sb.push_back(model(o, a, b));
    endtask

    task automatic collect(input int hold);
        int   k;
        bit   busy_ok;
        exp_t e;
        k       = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (!busy) busy_ok = 1'b0;
        end while (!resp_valid && k < 100);
        check("busy_during_op", {31'b0, busy_ok}, 32'd1);
        check("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
        check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("latency", k, e.lat);
            check("result", result, e.res);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                req_valid = 1'b1;
                op        = div_op_e'($urandom_range(0, 3));
                dividend  = $urandom;
                divisor   = $urandom;
                @(posedge clk);
                #1;
                check("hold_result", result, e.res);
                check("hold_valid", {31'b0, resp_valid}, 32'd1);
                check("hold_req_ready", {31'b0, req_ready}, 32'd0);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
        check("post_hs_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("post_hs_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        op         = DIV_OP_DIV;
        dividend   = '0;
        divisor    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(DIV_OP_DIV, 32'd20, 32'hFFFF_FFFD, 1'b1);
        check("div_20_m3_const", sb[0].res, 32'hFFFF_FFFA);
        collect(0);
        issue(DIV_OP_REM, 32'hFFFF_FFEC, 32'd3, 1'b1);
        collect(0);
        issue(DIV_OP_REMU, 32'hFFFF_FFEC, 32'd3, 1'b1);
        collect(0);
        issue(DIV_OP_DIVU, 32'hFFFF_FFEC, 32'd3, 1'b1);
        check("divu_const", sb[0].res, 32'h5555_554E);
        collect(0);
        issue(DIV_OP_DIVU, 32'd7, 32'd0, 1'b1);
        collect(0);
        issue(DIV_OP_REM, 32'd7, 32'd0, 1'b1);
        collect(0);
        issue(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        collect(0);
        issue(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        collect(0);
        issue(DIV_OP_DIV, 32'd100, 32'd7, 1'b1);
        collect(5);

        issue(DIV_OP_DIVU, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        check("busy_before_rst", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(DIV_OP_DIVU, 32'd9, 32'd2, 1'b1);
        collect(0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(1, 20);
            if (i[0]) a = -a;
            issue(div_op_e'(i % 4), a, b, 1'b1);
            collect(i % 3);
        end

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
